// File: rtl/am_seek_ctrl.sv
// AM tuning/seek controller: programs the NCO phase increment, waits for the CIC chain to
// settle, averages the demodulated level and optionally steps through the band until a station hits.
module am_seek_ctrl #(
  parameter int unsigned NUM_CH    = 121,
  parameter logic [39:0] BASE_INC  = 40'd11676813487,
  parameter logic [39:0] STEP_INC  = 40'd197912093,
  parameter int unsigned SETTLE_N  = 4,
  parameter int unsigned LOG2_MEAS = 3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        cmd_tune,
  input  logic [6:0]  ch_in,
  input  logic        cmd_seek,
  input  logic [15:0] threshold,
  input  logic [15:0] sample,
  input  logic        sample_tick,
  output logic [39:0] phase_inc,
  output logic [6:0]  channel,
  output logic [15:0] level,
  output logic        busy,
  output logic        locked,
  output logic        done
);

  localparam int unsigned AccW       = 16 + LOG2_MEAS;
  localparam logic [6:0]  LastCh     = 7'(NUM_CH - 1);
  localparam logic [7:0]  SettleLast = 8'(SETTLE_N - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StMeasure, StDecide} state_e;

  state_e                 state_q, state_d;
  logic                   seek_q, seek_d;
  logic [6:0]             tgt_q, tgt_d;
  logic [6:0]             origin_q, origin_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [7:0]             settle_q, settle_d;
  logic [LOG2_MEAS-1:0]   meas_q, meas_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [39:0]            phase_d;
  logic [6:0]             channel_d;
  logic [15:0]            level_d;
  logic                   busy_d, locked_d, done_d;

  logic [6:0]  tune_tgt;
  logic [15:0] avg;
  logic        hit;

  function automatic logic [6:0] inc_ch(input logic [6:0] c);
    return (c == LastCh) ? 7'd0 : c + 7'd1;
  endfunction

  assign tune_tgt = (ch_in > LastCh) ? LastCh : ch_in;
  assign avg      = acc_q[AccW-1:LOG2_MEAS];
  assign hit      = (avg >= threshold);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_tune) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:    if (cmd_seek) state_d = StLoad;
        StLoad:    if (cnt_q == 7'd0) state_d = StSettle;
        StSettle:  if (sample_tick && settle_q == SettleLast) state_d = StMeasure;
        StMeasure: if (sample_tick && meas_q == '1) state_d = StDecide;
        StDecide:  state_d = (seek_q && !hit) ? StLoad : StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    seek_d    = seek_q;
    tgt_d     = tgt_q;
    origin_d  = origin_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    meas_d    = meas_q;
    acc_d     = acc_q;
    phase_d   = phase_inc;
    channel_d = channel;
    level_d   = level;
    locked_d  = locked;
    done_d    = 1'b0;
    busy_d    = (state_d != StIdle);
    if (cmd_tune) begin
      // A tune always restarts from BASE_INC, aborting whatever was running.
      seek_d   = 1'b0;
      tgt_d    = tune_tgt;
      origin_d = tune_tgt;
      phase_d  = BASE_INC;
      cnt_d    = tune_tgt;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_seek) begin
            seek_d   = 1'b1;
            origin_d = channel;
            tgt_d    = inc_ch(channel);
            if (channel == LastCh) begin
              phase_d = BASE_INC;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = 7'd1;
            end
          end
        end
        StLoad: begin
          if (cnt_q != 7'd0) begin
            phase_d = phase_inc + STEP_INC;
            cnt_d   = cnt_q - 7'd1;
          end else begin
            channel_d = tgt_q;
            settle_d  = 8'd0;
          end
        end
        StSettle: begin
          if (sample_tick) begin
            if (settle_q == SettleLast) begin
              acc_d  = '0;
              meas_d = '0;
            end else begin
              settle_d = settle_q + 8'd1;
            end
          end
        end
        StMeasure: begin
          if (sample_tick) begin
            acc_d  = acc_q + AccW'(sample);
            meas_d = meas_q + LOG2_MEAS'(1);
          end
        end
        StDecide: begin
          level_d = avg;
          if (!seek_q || hit) begin
            locked_d = hit;
            done_d   = 1'b1;
          end else if (tgt_q != origin_q) begin
            tgt_d = inc_ch(tgt_q);
            if (tgt_q == LastCh) begin
              phase_d = BASE_INC;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = 7'd1;
            end
          end else begin
            // Whole band scanned without a hit: fall back to a plain tune of the origin.
            seek_d  = 1'b0;
            tgt_d   = origin_q;
            phase_d = BASE_INC;
            cnt_d   = origin_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      seek_q    <= 1'b0;
      tgt_q     <= 7'd0;
      origin_q  <= 7'd0;
      cnt_q     <= 7'd0;
      settle_q  <= 8'd0;
      meas_q    <= '0;
      acc_q     <= '0;
      phase_inc <= BASE_INC;
      channel   <= 7'd0;
      level     <= 16'd0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      done      <= 1'b0;
    end else begin
      seek_q    <= seek_d;
      tgt_q     <= tgt_d;
      origin_q  <= origin_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      meas_q    <= meas_d;
      acc_q     <= acc_d;
      phase_inc <= phase_d;
      channel   <= channel_d;
      level     <= level_d;
      busy      <= busy_d;
      locked    <= locked_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_am_seek_ctrl.sv
// Directed bench for am_seek_ctrl: tune, seek, band wrap, abort, priority, clamp and reset.
module tb_am_seek_ctrl;

  localparam logic [39:0] Base = 40'd11676813487;

  logic        clk = 1'b0;
  logic        RST;
  logic        cmd_tune, cmd_seek, sample_tick;
  logic [6:0]  ch_in;
  logic [15:0] threshold, sample;
  logic [39:0] phase_inc;
  logic [6:0]  channel;
  logic [15:0] level;
  logic        busy, locked, done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int smode = 0;
  bit tick_en = 1'b0;
  int tdiv = 0;
  int n, d0;

  bit          wrap_arm = 1'b0, wrap_seen = 1'b0;
  logic [39:0] wrap_phase;
  logic [6:0]  wrap_prev, prev_ch;

  am_seek_ctrl dut (
    .clk(clk), .RST(RST), .cmd_tune(cmd_tune), .ch_in(ch_in), .cmd_seek(cmd_seek),
    .threshold(threshold), .sample(sample), .sample_tick(sample_tick),
    .phase_inc(phase_inc), .channel(channel), .level(level), .busy(busy),
    .locked(locked), .done(done)
  );

  always #5 clk = ~clk;

  // Radio model: one sample tick every third cycle, level chosen per channel.
  initial begin
    sample_tick = 1'b0;
    sample = 16'h0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == 2) ? 0 : tdiv + 1;
      sample_tick = tick_en && (tdiv == 0);
      case (smode)
        0:       sample = 16'h1000;
        1:       sample = (channel >= 7'd50) ? 16'h3000 : 16'h0800;
        default: sample = 16'h0100;
      endcase
    end
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  always @(negedge clk) begin
    if (wrap_arm && !wrap_seen && channel == 7'd0) begin
      wrap_seen  = 1'b1;
      wrap_phase = phase_inc;
      wrap_prev  = prev_ch;
    end
    prev_ch = channel;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tune(input logic [6:0] ch);
    ch_in = ch;
    cmd_tune = 1'b1;
    @(negedge clk);
    cmd_tune = 1'b0;
  endtask

  task automatic pulse_seek();
    cmd_seek = 1'b1;
    @(negedge clk);
    cmd_seek = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, done, 1);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  task automatic wait_ch(input logic [6:0] ch, input int budget);
    int k = 0;
    while (channel !== ch && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_channel", channel, ch);
  endtask

  initial begin
    RST = 1'b1;
    cmd_tune = 1'b0;
    cmd_seek = 1'b0;
    ch_in = 7'd0;
    threshold = 16'h0800;
    repeat (2) @(negedge clk);
    check("rst_phase", phase_inc, Base);
    check("rst_channel", channel, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_done", done, 0);
    RST = 1'b0;
    repeat (2) @(negedge clk);

    // Direct tune to 45 with no ticks: count LOAD cycles until the channel updates.
    pulse_tune(7'd45);
    check("tune45_busy", busy, 1);
    n = 0;
    while (channel !== 7'd45 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tune45_load_cycles", n, 46);
    check("tune45_phase", phase_inc, 40'd20582857672);
    tick_en = 1'b1;
    d0 = done_cnt;
    wait_done("tune45", 200);
    check("tune45_level", level, 16'h1000);
    check("tune45_locked", locked, 1);
    check("tune45_idle", busy, 0);
    check("tune45_done_count", done_cnt - d0, 1);

    // Seek upward from 45: first station above threshold is channel 50.
    smode = 1;
    threshold = 16'h2000;
    d0 = done_cnt;
    pulse_seek();
    wait_done("seek50", 2000);
    check("seek50_channel", channel, 50);
    check("seek50_phase", phase_inc, 40'd21572418137);
    check("seek50_level", level, 16'h3000);
    check("seek50_locked", locked, 1);
    check("seek50_done_count", done_cnt - d0, 1);

    // Empty band: seek from 45 wraps through 0 and falls back to 45.
    smode = 2;
    pulse_tune(7'd45);
    wait_done("retune45", 500);
    d0 = done_cnt;
    wrap_arm = 1'b1;
    pulse_seek();
    wait_done("seekwrap", 20000);
    wrap_arm = 1'b0;
    check("wrap_seen", wrap_seen, 1);
    check("wrap_prev_ch", wrap_prev, 120);
    check("wrap_phase", wrap_phase, Base);
    check("seekwrap_channel", channel, 45);
    check("seekwrap_locked", locked, 0);
    check("seekwrap_level", level, 16'h0100);
    check("seekwrap_done_count", done_cnt - d0, 1);

    // Abort a seek mid-measurement with a tune to channel 0.
    d0 = done_cnt;
    pulse_seek();
    wait_ch(7'd46, 200);
    repeat (20) @(negedge clk);
    pulse_tune(7'd0);
    @(negedge clk);
    check("abort_channel", channel, 0);
    check("abort_phase", phase_inc, Base);
    check("abort_busy", busy, 1);
    wait_done("abort", 500);
    check("abort_done_count", done_cnt - d0, 1);
    check("abort_level", level, 16'h0100);
    check("abort_locked", locked, 0);

    // Tune and seek together: tune to 10 wins.
    ch_in = 7'd10;
    cmd_tune = 1'b1;
    cmd_seek = 1'b1;
    @(negedge clk);
    cmd_tune = 1'b0;
    cmd_seek = 1'b0;
    wait_done("prio", 500);
    check("prio_channel", channel, 10);
    check("prio_phase", phase_inc, 40'd13655934417);

    // Clamp ch_in=127 to 120, and a seek issued while busy is dropped.
    d0 = done_cnt;
    pulse_tune(7'd127);
    repeat (5) @(negedge clk);
    pulse_seek();
    wait_done("clamp", 800);
    check("clamp_channel", channel, 120);
    check("clamp_phase", phase_inc, 40'd35426264647);
    repeat (5) @(negedge clk);
    check("seek_busy_ignored", busy, 0);
    check("clamp_done_count", done_cnt - d0, 1);

    // Asynchronous reset mid-MEASURE.
    pulse_tune(7'd5);
    wait_ch(7'd5, 200);
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    RST = 1'b1;
    #1;
    check("arst_phase", phase_inc, Base);
    check("arst_channel", channel, 0);
    check("arst_busy", busy, 0);
    check("arst_level", level, 0);
    check("arst_locked", locked, 0);
    repeat (3) @(negedge clk);
    RST = 1'b0;
    d0 = done_cnt;
    repeat (60) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
